// File: rtl/prf_debug_access_pkg.sv
// Shared types and constants for the PRF debug-port initiator.
package prf_debug_access_pkg;

  localparam int unsigned PRF_DBG_PHYS_LOG  = 7;
  localparam int unsigned PRF_DBG_BYTE_OFS  = 3;
  localparam int unsigned PRF_DBG_SRAM_W    = 8;
  localparam int unsigned PRF_DBG_DATA_W    = 64;
  localparam int unsigned PRF_DBG_NUM_BYTES = PRF_DBG_DATA_W / PRF_DBG_SRAM_W;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StResp
  } prf_dbg_state_e;

  typedef struct packed {
    logic                        write;
    logic [PRF_DBG_PHYS_LOG-1:0] addr;
    logic [PRF_DBG_DATA_W-1:0]   wdata;
  } prf_dbg_req_t;

  typedef struct packed {
    logic                      error;
    logic [PRF_DBG_DATA_W-1:0] rdata;
  } prf_dbg_rsp_t;

endpackage

// File: rtl/prf_dbg_rd_capture.sv
// Read-return tracking: RD_LAT-deep issue shift line and byte assembly register.
// asm_data_o already includes the byte landing this cycle; done_o flags the last byte.
module prf_dbg_rd_capture
  import prf_debug_access_pkg::*;
#(
  parameter int unsigned BYTE_OFS = PRF_DBG_BYTE_OFS,
  parameter int unsigned SRAM_W   = PRF_DBG_SRAM_W,
  parameter int unsigned DATA_W   = PRF_DBG_DATA_W,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_valid_i,
  input  logic [BYTE_OFS-1:0] issue_idx_i,
  input  logic [SRAM_W-1:0]   rd_data_i,
  output logic [DATA_W-1:0]   asm_data_o,
  output logic                done_o
);

  localparam logic [BYTE_OFS-1:0] LastIdx = BYTE_OFS'(PRF_DBG_NUM_BYTES - 1);

  logic                tap_valid;
  logic [BYTE_OFS-1:0] tap_idx;
  logic [DATA_W-1:0]   asm_q, asm_d;

  if (RD_LAT == 0) begin : g_no_lat
    assign tap_valid = issue_valid_i;
    assign tap_idx   = issue_idx_i;
  end else begin : g_lat
    logic [RD_LAT-1:0]               vld_q;
    logic [RD_LAT-1:0][BYTE_OFS-1:0] idx_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= '0;
        idx_q <= '0;
      end else begin
        vld_q[0] <= issue_valid_i;
        idx_q[0] <= issue_idx_i;
        for (int i = 1; i < int'(RD_LAT); i++) begin
          vld_q[i] <= vld_q[i-1];
          idx_q[i] <= idx_q[i-1];
        end
      end
    end

    assign tap_valid = vld_q[RD_LAT-1];
    assign tap_idx   = idx_q[RD_LAT-1];
  end

  always_comb begin
    asm_d = asm_q;
    if (tap_valid) asm_d[int'(tap_idx)*SRAM_W +: SRAM_W] = rd_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) asm_q <= '0;
    else         asm_q <= asm_d;
  end

  assign asm_data_o = asm_d;
  assign done_o     = tap_valid && (tap_idx == LastIdx);

endmodule

// File: rtl/prf_debug_access.sv
// Debug-port initiator: turns whole-register requests into eight byte accesses on the PRF port.
// Define PRF_DEBUG_READBACK_EN to read back every write and flag mismatches on rsp_error_o.
module prf_debug_access
  import prf_debug_access_pkg::*;
#(
  parameter int unsigned PHYS_LOG = PRF_DBG_PHYS_LOG,
  parameter int unsigned BYTE_OFS = PRF_DBG_BYTE_OFS,
  parameter int unsigned SRAM_W   = PRF_DBG_SRAM_W,
  parameter int unsigned DATA_W   = PRF_DBG_DATA_W,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_write_i,
  input  logic [PHYS_LOG-1:0]          req_addr_i,
  input  logic [DATA_W-1:0]            req_wdata_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [DATA_W-1:0]            rsp_rdata_o,
  output logic                         rsp_error_o,
  output logic                         busy_o,
  output logic [PHYS_LOG+BYTE_OFS-1:0] debugPRFAddr_o,
  output logic [SRAM_W-1:0]            debugPRFWrData_o,
  output logic                         debugPRFWrEn_o,
  input  logic [SRAM_W-1:0]            debugPRFRdData_i
);

`ifdef PRF_DEBUG_READBACK_EN
  localparam bit ReadbackEn = 1'b1;
`else
  localparam bit ReadbackEn = 1'b0;
`endif

  localparam logic [BYTE_OFS-1:0] LastByte = BYTE_OFS'(PRF_DBG_NUM_BYTES - 1);

  prf_dbg_state_e               state_q;
  logic [BYTE_OFS-1:0]          cnt_q;
  logic [BYTE_OFS-1:0]          cnt_nxt;
  prf_dbg_req_t                 req_q;
  prf_dbg_rsp_t                 rsp_q;
  prf_dbg_rsp_t                 rsp_rd;
  logic [PHYS_LOG+BYTE_OFS-1:0] dbg_addr_q;
  logic [SRAM_W-1:0]            dbg_wdata_q;
  logic                         dbg_wen_q;
  logic [DATA_W-1:0]            asm_data;
  logic                         cap_done;

  assign cnt_nxt = cnt_q + 1'b1;

  prf_dbg_rd_capture #(
    .BYTE_OFS(BYTE_OFS),
    .SRAM_W  (SRAM_W),
    .DATA_W  (DATA_W),
    .RD_LAT  (RD_LAT)
  ) u_rd_capture (
    .clk_i        (clk),
    .rst_ni       (reset),
    .issue_valid_i(state_q == StRead),
    .issue_idx_i  (cnt_q),
    .rd_data_i    (debugPRFRdData_i),
    .asm_data_o   (asm_data),
    .done_o       (cap_done)
  );

  // A read completing for a write request only happens in readback mode.
  always_comb begin
    rsp_rd.rdata = asm_data;
    rsp_rd.error = ReadbackEn && req_q.write && (asm_data != req_q.wdata);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      req_q       <= '0;
      rsp_q       <= '0;
      dbg_addr_q  <= '0;
      dbg_wdata_q <= '0;
      dbg_wen_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            req_q      <= '{write: req_write_i, addr: req_addr_i, wdata: req_wdata_i};
            cnt_q      <= '0;
            dbg_addr_q <= {req_addr_i, {BYTE_OFS{1'b0}}};
            if (req_write_i) begin
              dbg_wdata_q <= req_wdata_i[SRAM_W-1:0];
              dbg_wen_q   <= 1'b1;
              state_q     <= StWrite;
            end else begin
              state_q <= StRead;
            end
          end
        end
        StWrite: begin
          if (cnt_q != LastByte) begin
            cnt_q       <= cnt_nxt;
            dbg_addr_q  <= {req_q.addr, cnt_nxt};
            dbg_wdata_q <= req_q.wdata[int'(cnt_nxt)*SRAM_W +: SRAM_W];
          end else begin
            dbg_wen_q <= 1'b0;
`ifdef PRF_DEBUG_READBACK_EN
            cnt_q      <= '0;
            dbg_addr_q <= {req_q.addr, {BYTE_OFS{1'b0}}};
            state_q    <= StRead;
`else
            rsp_q   <= '{error: 1'b0, rdata: req_q.wdata};
            state_q <= StResp;
`endif
          end
        end
        StRead: begin
          if (cnt_q != LastByte) begin
            cnt_q      <= cnt_nxt;
            dbg_addr_q <= {req_q.addr, cnt_nxt};
          end else if (cap_done) begin
            rsp_q   <= rsp_rd;
            state_q <= StResp;
          end else begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (cap_done) begin
            rsp_q   <= rsp_rd;
            state_q <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o      = (state_q == StIdle);
  assign busy_o           = (state_q != StIdle);
  assign rsp_valid_o      = (state_q == StResp);
  assign rsp_rdata_o      = rsp_q.rdata;
  assign rsp_error_o      = rsp_q.error;
  assign debugPRFAddr_o   = dbg_addr_q;
  assign debugPRFWrData_o = dbg_wdata_q;
  assign debugPRFWrEn_o   = dbg_wen_q;

endmodule

// File: tb/tb_prf_debug_access.sv
// Bench for prf_debug_access: four instances (RD_LAT 0..3) driven in lockstep, each with
// its own byte-wide register-file model; vectors carry hand-computed expected data.
module tb_prf_debug_access;

`ifdef PRF_DEBUG_READBACK_EN
  localparam bit Rb = 1'b1;
`else
  localparam bit Rb = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [6:0]  req_addr;
  logic [63:0] req_wdata;
  logic        rsp_ready;
  logic        stuck;

  logic [3:0]  req_ready, rsp_valid, rsp_error, busy, dbg_wen;
  logic [63:0] rsp_rdata [4];
  logic [9:0]  dbg_addr  [4];
  logic [7:0]  dbg_wd    [4];
  logic [7:0]  dbg_rd    [4];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int Tap = (g == 0) ? 0 : g - 1;
    logic [7:0] mem [1024];
    logic [9:0] apipe [4];
    logic [9:0] raddr;

    prf_debug_access #(.RD_LAT(g)) u_dut (
      .clk             (clk),
      .reset           (rst_n),
      .req_valid_i     (req_valid),
      .req_ready_o     (req_ready[g]),
      .req_write_i     (req_write),
      .req_addr_i      (req_addr),
      .req_wdata_i     (req_wdata),
      .rsp_valid_o     (rsp_valid[g]),
      .rsp_ready_i     (rsp_ready),
      .rsp_rdata_o     (rsp_rdata[g]),
      .rsp_error_o     (rsp_error[g]),
      .busy_o          (busy[g]),
      .debugPRFAddr_o  (dbg_addr[g]),
      .debugPRFWrData_o(dbg_wd[g]),
      .debugPRFWrEn_o  (dbg_wen[g]),
      .debugPRFRdData_i(dbg_rd[g])
    );

    always @(posedge clk) begin
      if (dbg_wen[g]) mem[dbg_addr[g]] <= dbg_wd[g];
      apipe[0] <= dbg_addr[g];
      for (int i = 1; i < 4; i++) apipe[i] <= apipe[i-1];
    end

    assign raddr     = (g == 0) ? dbg_addr[g] : apipe[Tap];
    assign dbg_rd[g] = (stuck && raddr[2:0] == 3'd3) ? 8'h00 : mem[raddr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_req_ready[%0d]", tag, i), 64'(req_ready[i]), 64'd1);
      chk($sformatf("%s_rsp_valid[%0d]", tag, i), 64'(rsp_valid[i]), 64'd0);
      chk($sformatf("%s_rsp_rdata[%0d]", tag, i), rsp_rdata[i], 64'd0);
      chk($sformatf("%s_rsp_error[%0d]", tag, i), 64'(rsp_error[i]), 64'd0);
      chk($sformatf("%s_busy[%0d]", tag, i), 64'(busy[i]), 64'd0);
      chk($sformatf("%s_dbg_addr[%0d]", tag, i), 64'(dbg_addr[i]), 64'd0);
      chk($sformatf("%s_dbg_wdata[%0d]", tag, i), 64'(dbg_wd[i]), 64'd0);
      chk($sformatf("%s_dbg_wen[%0d]", tag, i), 64'(dbg_wen[i]), 64'd0);
    end
  endtask

  // One request on all instances; per-cycle port checks, latency, response, optional hold.
  task automatic do_req(input logic wr, input logic [6:0] ridx, input logic [63:0] wdata,
                        input logic [63:0] exp_rdata, input logic exp_err, input int hold);
    int  lat     [4];
    int  exp_lat [4];
    bit  all_seen;
    for (int i = 0; i < 4; i++) begin
      lat[i]     = -1;
      exp_lat[i] = wr ? (Rb ? 17 + i : 9) : 9 + i;
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("ready_before[%0d]", i), 64'(req_ready[i]), 64'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = ridx;
    req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      all_seen = 1'b1;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("wen[%0d]@T+%0d", i, k), 64'(dbg_wen[i]), 64'(wr && k <= 8));
        if (k <= 8)
          chk($sformatf("addr[%0d]@T+%0d", i, k), 64'(dbg_addr[i]), 64'({ridx, 3'(k - 1)}));
        if (Rb && wr && k >= 9 && k <= 16)
          chk($sformatf("rb_addr[%0d]@T+%0d", i, k), 64'(dbg_addr[i]), 64'({ridx, 3'(k - 9)}));
        if (wr && k <= 8)
          chk($sformatf("wdata[%0d]@T+%0d", i, k), 64'(dbg_wd[i]), 64'(wdata[8*(k-1) +: 8]));
        if (lat[i] < 0 && rsp_valid[i]) lat[i] = k;
        if (lat[i] < 0) all_seen = 1'b0;
      end
      if (all_seen) break;
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rsp_latency[%0d]", i), 64'(lat[i]), 64'(exp_lat[i]));
      chk($sformatf("rsp_rdata[%0d]", i), rsp_rdata[i], exp_rdata);
      chk($sformatf("rsp_error[%0d]", i), 64'(rsp_error[i]), 64'(exp_err));
    end
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = ridx + 7'd1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("hold%0d_rsp_valid[%0d]", h, i), 64'(rsp_valid[i]), 64'd1);
        chk($sformatf("hold%0d_rdata[%0d]", h, i), rsp_rdata[i], exp_rdata);
        chk($sformatf("hold%0d_req_ready[%0d]", h, i), 64'(req_ready[i]), 64'd0);
        chk($sformatf("hold%0d_busy[%0d]", h, i), 64'(busy[i]), 64'd1);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("after_rsp_ready[%0d]", i), 64'(req_ready[i]), 64'd1);
      chk($sformatf("after_rsp_valid[%0d]", i), 64'(rsp_valid[i]), 64'd0);
      chk($sformatf("after_rsp_busy[%0d]", i), 64'(busy[i]), 64'd0);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [6:0]  ridx;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{1'b1, 7'd5,   64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
    vecs[1] = '{1'b0, 7'd5,   64'h0,                64'h0123456789ABCDEF};
    vecs[2] = '{1'b1, 7'd0,   64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00D};
    vecs[3] = '{1'b1, 7'd127, 64'h8000000000000001, 64'h8000000000000001};
    vecs[4] = '{1'b0, 7'd0,   64'h0,                64'hDEADBEEFCAFEF00D};
    vecs[5] = '{1'b0, 7'd127, 64'h0,                64'h8000000000000001};
    vecs[6] = '{1'b1, 7'd6,   64'h1122334455667788, 64'h1122334455667788};
    vecs[7] = '{1'b0, 7'd5,   64'h0,                64'h0123456789ABCDEF};
    vecs[8] = '{1'b0, 7'd6,   64'h0,                64'h1122334455667788};

    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    stuck     = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 9; v++)
      do_req(vecs[v].wr, vecs[v].ridx, vecs[v].wdata, vecs[v].exp_rdata, 1'b0, 0);

    // Response back-pressure with a competing request held valid.
    do_req(1'b0, 7'd5, 64'h0, 64'h0123456789ABCDEF, 1'b0, 5);

    // Asynchronous reset in the middle of a write (cycle T+4).
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 7'd9;
    req_wdata = 64'hA5A5A5A5A5A5A5A5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mid_wen[%0d]", i), 64'(dbg_wen[i]), 64'd1);
      chk($sformatf("mid_addr[%0d]", i), 64'(dbg_addr[i]), 64'({7'd9, 3'd3}));
    end
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) chk($sformatf("no_rsp[%0d]", i), 64'(rsp_valid[i]), 64'd0);
    end
    do_req(1'b1, 7'd9, 64'h0F1E2D3C4B5A6978, 64'h0F1E2D3C4B5A6978, 1'b0, 0);
    do_req(1'b0, 7'd9, 64'h0,                64'h0F1E2D3C4B5A6978, 1'b0, 0);

`ifdef PRF_DEBUG_READBACK_EN
    stuck = 1'b1;
    do_req(1'b1, 7'd7, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF00FFFFFF, 1'b1, 0);
    stuck = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
